// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-facing signals of the hazard/sequencing controller.
//   The "slave" modport is the controller side: it observes ID/EX hazard
//   sources and the instruction-memory wait, and it drives fetch-stage control.
//   The "master" modport is the pipeline side.
//
//   Pipeline -> controller
//     rs1_ID, rs2_ID    [4:0]   source registers of the instruction in ID
//     rd_EX             [4:0]   destination register of the instruction in EX
//     MemRead_EX                EX instruction is a load
//     branch_taken_EX           branch/jump in EX resolved taken
//     branch_target_EX  [XLEN]  resolved target (signed PC)
//     imem_busy                 current fetch not complete; IF must hold
//   Controller -> pipeline
//     PCSrc_IF                  1 = PC mux selects PCTarget_IF
//     PCTarget_IF       [XLEN]  redirect target
//     PCWrite                   PC register enable
//     Write_IFID                IF/ID load enable
//     flush_IF                  zero IF/ID at next edge
//     flush_ID                  bubble into ID/EX at next edge
//     imem_timeout              sticky instruction-memory watchdog flag
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic        [4:0]      rs1_ID;
  logic        [4:0]      rs2_ID;
  logic        [4:0]      rd_EX;
  logic                   MemRead_EX;
  logic                   branch_taken_EX;
  logic signed [XLEN-1:0] branch_target_EX;
  logic                   imem_busy;

  logic                   PCSrc_IF;
  logic signed [XLEN-1:0] PCTarget_IF;
  logic                   PCWrite;
  logic                   Write_IFID;
  logic                   flush_IF;
  logic                   flush_ID;
  logic                   imem_timeout;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, MemRead_EX, branch_taken_EX,
           branch_target_EX, imem_busy,
    input  PCSrc_IF, PCTarget_IF, PCWrite, Write_IFID, flush_IF, flush_ID,
           imem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, MemRead_EX, branch_taken_EX,
           branch_target_EX, imem_busy,
    output PCSrc_IF, PCTarget_IF, PCWrite, Write_IFID, flush_IF, flush_ID,
           imem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard/sequencing controller for the fetch stage and the IF/ID register.
//   - Detects load-use hazards and inserts one bubble into ID/EX while
//     holding PC and IF/ID.
//   - Applies taken-branch redirects resolved in EX. If the instruction
//     memory is busy when the branch resolves, the target is parked in
//     redir_q and applied on the first non-busy cycle (REDIR_PEND state).
//   - Holds IF while the instruction memory is busy and runs a watchdog that
//     raises a sticky imem_timeout flag after IMEM_TIMEOUT consecutive busy
//     cycles.
//   All fetch controls are combinational from registered state plus the
//   current inputs, so they act in the same cycle the condition is seen.
//
// Parameters
//   XLEN          PC / target width
//   IMEM_TIMEOUT  consecutive imem_busy cycles before imem_timeout sets
//                 (1 .. 2^TO_W-1)
//   TO_W          watchdog counter width
//   CNT_W         performance counter width (HAZ_PERF_CNT_EN only)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; wins over everything and
//              discards any pending redirect
//   bus        hazard_ctrl_if.slave (ID/EX hazard sources in, fetch
//              controls out; see hazard_ctrl_if.sv)
//   stall_cnt  [CNT_W] load-use stall cycles   (HAZ_PERF_CNT_EN only)
//   flush_cnt  [CNT_W] redirect-apply cycles   (HAZ_PERF_CNT_EN only)
//
// Build option
//   HAZ_PERF_CNT_EN  when defined, adds the wrapping stall_cnt/flush_cnt
//                    performance counters; when undefined those ports and
//                    registers do not exist and behaviour is otherwise the same.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int IMEM_TIMEOUT = 255,
  parameter int TO_W         = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(IMEM_TIMEOUT);

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 never carries a dependency.
  function automatic logic detect_load_use(input logic       mem_read,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Saturating increment for the watchdog counter.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                 state_q, state_nxt;
  logic signed [XLEN-1:0] redir_q, redir_nxt;
  logic        [TO_W-1:0] to_cnt_q, to_cnt_nxt;
  logic                   imem_timeout_q;

  logic load_use;
  logic stall_evt;    // rule-3 load-use stall cycle
  logic redir_apply;  // cycle in which a redirect is steered into the PC

  assign load_use   = detect_load_use(bus.MemRead_EX, bus.rd_EX,
                                      bus.rs1_ID, bus.rs2_ID);
  assign to_cnt_nxt = bus.imem_busy ? sat_inc(to_cnt_q) : '0;

  assign bus.imem_timeout = imem_timeout_q;

  // ---- Next-state and same-cycle fetch control ----
  always_comb begin
    state_nxt       = state_q;
    redir_nxt       = redir_q;
    bus.PCSrc_IF    = 1'b0;
    bus.PCTarget_IF = redir_q;
    bus.PCWrite     = 1'b1;
    bus.Write_IFID  = 1'b1;
    bus.flush_IF    = 1'b0;
    bus.flush_ID    = 1'b0;
    stall_evt       = 1'b0;
    redir_apply     = 1'b0;

    if (rst) begin
      bus.PCTarget_IF = '0;
      bus.PCWrite     = 1'b0;
      bus.Write_IFID  = 1'b0;
      bus.flush_IF    = 1'b1;
      bus.flush_ID    = 1'b1;
      state_nxt       = RUN;
      redir_nxt       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.branch_taken_EX && !bus.imem_busy) begin
            // Redirect immediately; the wrong-path IF and ID instructions
            // are squashed. IF/ID loads but is flushed at the same edge.
            bus.PCSrc_IF    = 1'b1;
            bus.PCTarget_IF = bus.branch_target_EX;
            bus.flush_IF    = 1'b1;
            bus.flush_ID    = 1'b1;
            redir_apply     = 1'b1;
          end else if (bus.branch_taken_EX) begin
            // Fetch cannot accept a new PC yet: park the target and
            // squash the wrong path while waiting.
            redir_nxt      = bus.branch_target_EX;
            bus.PCWrite    = 1'b0;
            bus.Write_IFID = 1'b0;
            bus.flush_IF   = 1'b1;
            bus.flush_ID   = 1'b1;
            state_nxt      = REDIR_PEND;
          end else if (load_use) begin
            // The bubble moves the load on, so the hazard clears next
            // cycle: one bubble per occurrence.
            bus.PCWrite    = 1'b0;
            bus.Write_IFID = 1'b0;
            bus.flush_ID   = 1'b1;
            stall_evt      = 1'b1;
          end else if (bus.imem_busy) begin
            bus.PCWrite    = 1'b0;
            bus.Write_IFID = 1'b0;
            bus.flush_IF   = 1'b1;
          end
        end

        REDIR_PEND: begin
          // EX only holds bubbles here, so branch and load-use inputs
          // are not looked at.
          if (bus.imem_busy) begin
            bus.PCWrite    = 1'b0;
            bus.Write_IFID = 1'b0;
            bus.flush_IF   = 1'b1;
            bus.flush_ID   = 1'b1;
          end else begin
            bus.PCSrc_IF    = 1'b1;
            bus.PCTarget_IF = redir_q;
            bus.flush_IF    = 1'b1;
            bus.flush_ID    = 1'b1;
            redir_apply     = 1'b1;
            state_nxt       = RUN;
          end
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  // ---- State, parked redirect and watchdog registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      redir_q        <= '0;
      to_cnt_q       <= '0;
      imem_timeout_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      redir_q  <= redir_nxt;
      to_cnt_q <= to_cnt_nxt;
      // Flag sets on the edge at which the busy run reaches the limit.
      if (bus.imem_busy && (to_cnt_nxt >= TO_LIMIT))
        imem_timeout_q <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // ---- Performance counters (free-running, wrap) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt)
        stall_cnt <= stall_cnt + 1'b1;
      if (redir_apply)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Event strobes exist for the optional counters only.
  logic unused_evt;
  assign unused_evt = stall_evt ^ redir_apply;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int XLEN   = 32;
  localparam int TO_LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(
    .XLEN(XLEN), .IMEM_TIMEOUT(TO_LIM), .TO_W(8), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, m;
    logic [4:0]  rd, rs1, rs2;
    logic        bt;
    logic [31:0] tgt;
    logic        busy;
    logic        pcw, wif, fif, fid, pcs;
    logic [31:0] ptgt;
    logic        wc, pc;   // Write_IFID / PCSrc_IF are defined for this vector
  } vec_t;

  function automatic vec_t mk(input logic r, input logic m, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic bt, input logic [31:0] tgt, input logic busy,
                              input logic pcw, input logic wif, input logic fif,
                              input logic fid, input logic pcs, input logic [31:0] ptgt,
                              input logic wc, input logic pc);
    vec_t v;
    v.r = r; v.m = m; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.bt = bt; v.tgt = tgt;
    v.busy = busy; v.pcw = pcw; v.wif = wif; v.fif = fif; v.fid = fid; v.pcs = pcs;
    v.ptgt = ptgt; v.wc = wc; v.pc = pc;
    return v;
  endfunction

  vec_t vt[18];

  // ---------------- behavioural reference model ----------------
  logic [31:0] pend_q[$];   // redirect waiting for fetch to become free
  logic [31:0] last_redir;  // most recently parked target
  int          busy_run;
  bit          to_flag;
  int          m_stall, m_flush;
  // expected outputs for the current cycle
  logic        e_pcw, e_wif, e_fif, e_fid, e_pcs, c_wif, c_pcs, e_stall, e_apply;
  logic [31:0] e_ptgt;

  task automatic drive(input logic r, input logic m, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic bt, input logic [31:0] tgt, input logic busy);
    rst = r;
    bus.MemRead_EX = m; bus.rd_EX = rd; bus.rs1_ID = rs1; bus.rs2_ID = rs2;
    bus.branch_taken_EX = bt; bus.branch_target_EX = tgt; bus.imem_busy = busy;
  endtask

  task automatic model_eval();
    logic lu;
    lu = bus.MemRead_EX && bus.rd_EX != 0 &&
         (bus.rd_EX == bus.rs1_ID || bus.rd_EX == bus.rs2_ID);
    e_ptgt = last_redir; e_pcs = 0; c_pcs = 0; c_wif = 1; e_wif = 0;
    e_stall = 0; e_apply = 0;
    if (rst) begin
      {e_pcw, e_wif, e_fif, e_fid} = 4'b0011; c_pcs = 1; e_ptgt = 0;
    end else if (pend_q.size() != 0) begin
      if (bus.imem_busy) {e_pcw, e_wif, e_fif, e_fid} = 4'b0011;
      else begin
        e_pcs = 1; c_pcs = 1; e_ptgt = pend_q[0]; c_wif = 0;
        {e_pcw, e_fif, e_fid} = 3'b111; e_apply = 1;
      end
    end else if (bus.branch_taken_EX && !bus.imem_busy) begin
      e_pcs = 1; c_pcs = 1; e_ptgt = bus.branch_target_EX; c_wif = 0;
      {e_pcw, e_fif, e_fid} = 3'b111; e_apply = 1;
    end else if (bus.branch_taken_EX) begin
      {e_pcw, e_fif, e_fid} = 3'b011; c_wif = 0;
    end else if (lu) begin
      {e_pcw, e_wif, e_fif, e_fid} = 4'b0001; e_stall = 1;
    end else if (bus.imem_busy) begin
      {e_pcw, e_wif, e_fif, e_fid} = 4'b0010;
    end else begin
      {e_pcw, e_wif, e_fif, e_fid} = 4'b1100; c_pcs = 1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      pend_q.delete(); last_redir = 0; busy_run = 0; to_flag = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (pend_q.size() != 0) begin
        if (!bus.imem_busy) void'(pend_q.pop_front());
      end else if (bus.branch_taken_EX && bus.imem_busy) begin
        pend_q.push_back(bus.branch_target_EX);
        last_redir = bus.branch_target_EX;
      end
      busy_run = bus.imem_busy ? busy_run + 1 : 0;
      if (busy_run >= TO_LIM) to_flag = 1;
      m_stall += int'(e_stall);
      m_flush += int'(e_apply);
    end
  endtask

  // apply inputs, evaluate model mid-cycle
  task automatic step(input logic r, input logic m, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic bt, input logic [31:0] tgt, input logic busy);
    drive(r, m, rd, rs1, rs2, bt, tgt, busy);
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".PCWrite"},     32'(bus.PCWrite),  32'(e_pcw));
    check({tag, ".flush_IF"},    32'(bus.flush_IF), 32'(e_fif));
    check({tag, ".flush_ID"},    32'(bus.flush_ID), 32'(e_fid));
    check({tag, ".PCTarget_IF"}, bus.PCTarget_IF,   e_ptgt);
    check({tag, ".imem_timeout"}, 32'(bus.imem_timeout), 32'(to_flag));
    if (c_wif) check({tag, ".Write_IFID"}, 32'(bus.Write_IFID), 32'(e_wif));
    if (c_pcs) check({tag, ".PCSrc_IF"},   32'(bus.PCSrc_IF),   32'(e_pcs));
`ifdef HAZ_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cnt, 32'(m_stall));
    check({tag, ".flush_cnt"}, flush_cnt, 32'(m_flush));
`endif
  endtask

  initial begin
    logic busy_r;
    pend_q.delete(); last_redir = 0; busy_run = 0; to_flag = 0; m_stall = 0; m_flush = 0;

    //            r m rd rs1 rs2 bt tgt    busy pcw wif fif fid pcs ptgt  wc pc
    vt[0]  = mk(1,0,0, 0, 0, 0,32'h0,  0,   0,  0,  1,  1,  0,  32'h0, 1,1);
    vt[1]  = mk(1,0,0, 0, 0, 0,32'h0,  0,   0,  0,  1,  1,  0,  32'h0, 1,1);
    vt[2]  = mk(1,0,0, 0, 0, 0,32'h0,  0,   0,  0,  1,  1,  0,  32'h0, 1,1);
    vt[3]  = mk(0,0,0, 0, 0, 0,32'h0,  0,   1,  1,  0,  0,  0,  32'h0, 1,1);
    vt[4]  = mk(0,1,5, 0, 5, 0,32'h0,  0,   0,  0,  0,  1,  0,  32'h0, 1,0);
    vt[5]  = mk(0,1,0, 0, 0, 0,32'h0,  0,   1,  1,  0,  0,  0,  32'h0, 1,1);
    vt[6]  = mk(0,1,7, 7, 3, 0,32'h0,  0,   0,  0,  0,  1,  0,  32'h0, 1,0);
    vt[7]  = mk(0,1,5, 5, 0, 1,32'h40, 0,   1,  0,  1,  1,  1,  32'h40,0,1);
    vt[8]  = mk(0,0,0, 0, 0, 1,32'h80, 1,   0,  0,  1,  1,  0,  32'h0, 0,0);
    vt[9]  = mk(0,0,0, 0, 0, 1,32'hC0, 1,   0,  0,  1,  1,  0,  32'h80,1,0);
    vt[10] = mk(0,1,2, 2, 0, 0,32'h0,  1,   0,  0,  1,  1,  0,  32'h80,1,0);
    vt[11] = mk(0,0,0, 0, 0, 0,32'h0,  0,   1,  0,  1,  1,  1,  32'h80,0,1);
    vt[12] = mk(0,0,0, 0, 0, 0,32'h0,  0,   1,  1,  0,  0,  0,  32'h80,1,1);
    vt[13] = mk(0,0,0, 0, 0, 0,32'h0,  1,   0,  0,  1,  0,  0,  32'h80,1,0);
    vt[14] = mk(0,0,0, 0, 0, 0,32'h0,  0,   1,  1,  0,  0,  0,  32'h80,1,1);
    vt[15] = mk(0,0,0, 0, 0, 1,32'h100,1,   0,  0,  1,  1,  0,  32'h80,0,0);
    vt[16] = mk(1,0,0, 0, 0, 0,32'h0,  0,   0,  0,  1,  1,  0,  32'h0, 1,1);
    vt[17] = mk(0,0,0, 0, 0, 0,32'h0,  0,   1,  1,  0,  0,  0,  32'h0, 1,1);

    for (int i = 0; i < 18; i++) begin
      step(vt[i].r, vt[i].m, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].bt, vt[i].tgt, vt[i].busy);
      check($sformatf("vec%0d.PCWrite", i),     32'(bus.PCWrite),  32'(vt[i].pcw));
      check($sformatf("vec%0d.flush_IF", i),    32'(bus.flush_IF), 32'(vt[i].fif));
      check($sformatf("vec%0d.flush_ID", i),    32'(bus.flush_ID), 32'(vt[i].fid));
      check($sformatf("vec%0d.PCTarget_IF", i), bus.PCTarget_IF,   vt[i].ptgt);
      check($sformatf("vec%0d.imem_timeout", i), 32'(bus.imem_timeout), 32'h0);
      if (vt[i].wc) check($sformatf("vec%0d.Write_IFID", i), 32'(bus.Write_IFID), 32'(vt[i].wif));
      if (vt[i].pc) check($sformatf("vec%0d.PCSrc_IF", i),   32'(bus.PCSrc_IF),   32'(vt[i].pcs));
      advance();
    end

    // ---------------- watchdog sequence ----------------
    step(1,0,0,0,0,0,0,0); advance();
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0,0,0,0,1); check("to_short_run", 32'(bus.imem_timeout), 32'h0); advance();
    end
    step(0,0,0,0,0,0,0,0); check("to_after_gap", 32'(bus.imem_timeout), 32'h0); advance();
    for (int i = 0; i < 4; i++) begin
      step(0,0,0,0,0,0,0,1); check("to_before_limit", 32'(bus.imem_timeout), 32'h0); advance();
    end
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0,0,0,0,0); check("to_sticky", 32'(bus.imem_timeout), 32'h1); advance();
    end
    step(1,0,0,0,0,0,0,0); check("to_in_rst", 32'(bus.imem_timeout), 32'h1); advance();
    step(0,0,0,0,0,0,0,0); check("to_cleared", 32'(bus.imem_timeout), 32'h0); advance();

`ifdef HAZ_PERF_CNT_EN
    // ---------------- performance counter sequence ----------------
    step(1,0,0,0,0,0,0,0); advance();
    step(0,1,5,5,0,0,0,0); advance();
    step(0,0,0,0,0,0,0,0); advance();
    step(0,1,6,0,6,0,0,0); advance();
    step(0,0,0,0,0,0,0,0); advance();
    step(0,0,0,0,0,1,32'h40,0); advance();
    step(0,0,0,0,0,0,0,0);
    check("perf.stall_cnt", stall_cnt, 32'd2);
    check("perf.flush_cnt", flush_cnt, 32'd1);
    advance();
    step(1,0,0,0,0,0,0,0); advance();
    step(0,0,0,0,0,0,0,0);
    check("perf.stall_rst", stall_cnt, 32'd0);
    check("perf.flush_rst", flush_cnt, 32'd0);
    advance();
`endif

    // ---------------- randomized run against the model ----------------
    busy_r = 0;
    step(1,0,0,0,0,0,0,0); advance();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0),
           {$urandom_range(0, 32'hFFFF), 2'b00} ,
           busy_r);
      cmp_model("rnd");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
